// File: rtl/input_hs_fifo.sv
// Four-entry byte FIFO between a dav_/rfd producer handshake and a processor read port.
// Define INPUT_HS_FIFO_OVF_EN to build the sticky overflow status bit.
module input_hs_fifo (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_,
    input  logic       ior_,
    input  logic       addr,
    inout  wire  [7:0] data,
    input  logic       dav_,
    input  logic [7:0] byte_in,
    output logic       rfd
);

    typedef enum logic [0:0] {StIdle, StWaitRel} state_e;

    logic [7:0] mem_q [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] count_q, count_d;
    state_e     state_q, state_d;
    logic       rd_data_q, rfd_q;
    logic       rd_data, pop, push, full, empty, ovf_bit;
    logic [7:0] rd_val;

    assign full    = (count_q == 3'd4);
    assign empty   = (count_q == 3'd0);
    assign rd_data = !s_ && !ior_ && addr;
    // A read completes when the strobe deasserts.
    assign pop     = rd_data_q && !rd_data && !empty;
    // When full, a slot freed by a pop at the same edge may be reused.
    assign push    = (state_q == StIdle) && !dav_ && (!full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (push) state_d = StWaitRel;
            StWaitRel: if (dav_) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 3'd0;
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            rd_data_q <= 1'b0;
            rfd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_data_q <= rd_data;
            rfd_q     <= (state_d == StIdle) && (count_d != 3'd4);
            if (push) wptr_q <= wptr_q + 2'd1;
            if (pop)  rptr_q <= rptr_q + 2'd1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wptr_q] <= byte_in;
    end

`ifdef INPUT_HS_FIFO_OVF_EN
    logic ovf_q, dav_q, stat_q, stat_rd, viol;

    assign stat_rd = !s_ && !ior_ && !addr;
    assign viol    = (state_q == StIdle) && dav_q && !dav_ && full;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            dav_q  <= 1'b1;
            stat_q <= 1'b0;
        end else begin
            dav_q  <= dav_;
            stat_q <= stat_rd;
            if (viol)                   ovf_q <= 1'b1;
            else if (stat_q && !stat_rd) ovf_q <= 1'b0;
        end
    end

    assign ovf_bit = ovf_q;
`else
    assign ovf_bit = 1'b0;
`endif

    assign rfd    = rfd_q;
    assign rd_val = addr ? (empty ? 8'h00 : mem_q[rptr_q]) : {6'b0, ovf_bit, !empty};
    assign data   = (!s_ && !ior_) ? rd_val : 8'bz;

endmodule
